// File: rtl/chan_fifo_pkg.sv
// Shared constants for the channel FIFO bridge: address width, status byte
// layout and the command bits carried by a status-channel write.
// Latency: n/a (declarations only). Backpressure: n/a.
package chan_fifo_pkg;

    localparam int ADDR_W = 7;

    // Status byte layout returned by a status-channel read; bits [2:0] read as zero.
    localparam int ST_H2F_FULL  = 7;
    localparam int ST_H2F_EMPTY = 6;
    localparam int ST_F2H_FULL  = 5;
    localparam int ST_F2H_EMPTY = 4;
    localparam int ST_OVF       = 3;

    // Command bits in a status-channel write; other bits are don't-care.
    localparam int CMD_FLUSH_H2F = 0;
    localparam int CMD_FLUSH_F2H = 1;
    localparam int CMD_CLR_OVF   = 2;

    function automatic logic [7:0] pack_status(input logic h2f_full,
                                               input logic h2f_empty,
                                               input logic f2h_full,
                                               input logic f2h_empty,
                                               input logic ovf);
        logic [7:0] s;
        s               = '0;
        s[ST_H2F_FULL]  = h2f_full;
        s[ST_H2F_EMPTY] = h2f_empty;
        s[ST_F2H_FULL]  = f2h_full;
        s[ST_F2H_EMPTY] = f2h_empty;
        s[ST_OVF]       = ovf;
        return s;
    endfunction

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO with synchronous reset and synchronous flush.
// Latency: head_dat_out shows the oldest entry combinationally; a push is visible one edge later.
// Backpressure: push refused when full, pop refused when empty; full/empty come from registered count only.
// Ports: clk_in/reset_in clock and sync reset; flush_in empties on the next edge (beats push/pop);
//        push_in/push_dat_in write side; pop_in/head_dat_out read side; full_out/empty_out status.
module fifo_fwft #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             flush_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_dat_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] head_dat_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_out     = (cnt_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_out    = (cnt_q == '0);
    assign head_dat_out = mem_q[rd_ptr_q];

    // Acceptance looks only at registered full/empty, so a pop never frees
    // room for a push on the same edge.
    assign push_ok = push_in & ~full_out  & ~flush_in;
    assign pop_ok  = pop_in  & ~empty_out & ~flush_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   cnt_d = cnt_q - (DEPTH_LOG2 + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only observable once the count covers it.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_in;
    end

endmodule

// File: rtl/chan_fifo_bridge.sv
// Bridges comm_fpga host channels to NUM_CHAN pairs of byte FIFOs (h2f and f2h) with per-pair status/control.
// Latency: host read data is combinational from the f2h head; host writes land in h2f one edge later.
// Backpressure: chanGotRoom_out/chanGotData_out low when the addressed data channel is full/empty; app side valid/ready.
// Ports: clk_in/reset_in; host side chanAddr_in, chanDataFromHost_in, chanWrite_in, chanGotRoom_out,
//        chanDataToHost_out, chanRead_in, chanGotData_out; app side h2fData_out/h2fValid_out/h2fReady_in
//        and f2hData_in/f2hValid_in/f2hReady_out, one byte lane / bit per channel.
module chan_fifo_bridge
    import chan_fifo_pkg::*;
#(
    parameter int                NUM_CHAN   = 2,
    parameter int                DEPTH_LOG2 = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 7'h10
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [ADDR_W-1:0]     chanAddr_in,
    input  logic [7:0]            chanDataFromHost_in,
    input  logic                  chanWrite_in,
    output logic                  chanGotRoom_out,
    output logic [7:0]            chanDataToHost_out,
    input  logic                  chanRead_in,
    output logic                  chanGotData_out,
    output logic [8*NUM_CHAN-1:0] h2fData_out,
    output logic [NUM_CHAN-1:0]   h2fValid_out,
    input  logic [NUM_CHAN-1:0]   h2fReady_in,
    input  logic [8*NUM_CHAN-1:0] f2hData_in,
    input  logic [NUM_CHAN-1:0]   f2hValid_in,
    output logic [NUM_CHAN-1:0]   f2hReady_out
);

    logic [NUM_CHAN-1:0] data_sel;
    logic [NUM_CHAN-1:0] stat_sel;
    logic [NUM_CHAN-1:0] h2f_full, h2f_empty, f2h_full, f2h_empty;
    logic [NUM_CHAN-1:0] h2f_push, h2f_flush, f2h_pop, f2h_flush;
    logic [NUM_CHAN-1:0] ovf_q, ovf_d;
    logic [7:0]          f2h_head [NUM_CHAN];

    // Channel i owns the address pair BASE_ADDR+2i (data) and BASE_ADDR+2i+1 (status).
    always_comb begin
        data_sel = '0;
        stat_sel = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            data_sel[i] = (chanAddr_in == ADDR_W'(int'(BASE_ADDR) + 2 * i));
            stat_sel[i] = (chanAddr_in == ADDR_W'(int'(BASE_ADDR) + 2 * i + 1));
        end
    end

    for (genvar g = 0; g < NUM_CHAN; g++) begin : gen_chan
        assign h2f_push[g]  = data_sel[g] & chanWrite_in;
        assign f2h_pop[g]   = data_sel[g] & chanRead_in;
        assign h2f_flush[g] = stat_sel[g] & chanWrite_in & chanDataFromHost_in[CMD_FLUSH_H2F];
        assign f2h_flush[g] = stat_sel[g] & chanWrite_in & chanDataFromHost_in[CMD_FLUSH_F2H];

        fifo_fwft #(
            .WIDTH      (8),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_h2f (
            .clk_in       (clk_in),
            .reset_in     (reset_in),
            .flush_in     (h2f_flush[g]),
            .push_in      (h2f_push[g]),
            .push_dat_in  (chanDataFromHost_in),
            .pop_in       (h2fReady_in[g]),
            .head_dat_out (h2fData_out[8*g +: 8]),
            .full_out     (h2f_full[g]),
            .empty_out    (h2f_empty[g])
        );

        fifo_fwft #(
            .WIDTH      (8),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_f2h (
            .clk_in       (clk_in),
            .reset_in     (reset_in),
            .flush_in     (f2h_flush[g]),
            .push_in      (f2hValid_in[g]),
            .push_dat_in  (f2hData_in[8*g +: 8]),
            .pop_in       (f2h_pop[g]),
            .head_dat_out (f2h_head[g]),
            .full_out     (f2h_full[g]),
            .empty_out    (f2h_empty[g])
        );

        assign h2fValid_out[g] = ~h2f_empty[g];
        assign f2hReady_out[g] = ~f2h_full[g];
    end

    // Sticky overflow: a host byte offered to a full h2f FIFO is dropped and flagged.
    // Clear and set target different addresses, so they never collide.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (stat_sel[i] && chanWrite_in && chanDataFromHost_in[CMD_CLR_OVF]) ovf_d[i] = 1'b0;
            if (data_sel[i] && chanWrite_in && h2f_full[i])                      ovf_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) ovf_q <= '0;
        else          ovf_q <= ovf_d;
    end

    // Host-side mux: unmapped addresses read 0 and never stall the host.
    always_comb begin
        chanGotRoom_out    = 1'b1;
        chanGotData_out    = 1'b1;
        chanDataToHost_out = 8'h00;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (data_sel[i]) begin
                chanGotRoom_out    = ~h2f_full[i];
                chanGotData_out    = ~f2h_empty[i];
                chanDataToHost_out = f2h_head[i];
            end
            if (stat_sel[i]) begin
                chanDataToHost_out = pack_status(h2f_full[i], h2f_empty[i],
                                                 f2h_full[i], f2h_empty[i], ovf_q[i]);
            end
        end
    end

endmodule

// File: tb/tb_chan_fifo_bridge.sv
module tb_chan_fifo_bridge;

    localparam int          NC    = 2;
    localparam int          DEPTH = 16;
    localparam logic [6:0]  BASE  = 7'h10;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [6:0]  addr;
    logic [7:0]  din;
    logic        wr, rd;
    logic        room, gd;
    logic [7:0]  dout;
    logic [15:0] h2f_dat;
    logic [1:0]  h2f_vld, h2f_rdy;
    logic [15:0] f2h_dat;
    logic [1:0]  f2h_vld, f2h_rdy;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queues per FIFO plus overflow flags.
    logic [7:0] h2f_m [NC][$];
    logic [7:0] f2h_m [NC][$];
    logic       ovf_m [NC];

    chan_fifo_bridge #(.NUM_CHAN(2), .DEPTH_LOG2(4), .BASE_ADDR(7'h10)) dut (
        .clk_in              (clk),
        .reset_in            (rst),
        .chanAddr_in         (addr),
        .chanDataFromHost_in (din),
        .chanWrite_in        (wr),
        .chanGotRoom_out     (room),
        .chanDataToHost_out  (dout),
        .chanRead_in         (rd),
        .chanGotData_out     (gd),
        .h2fData_out         (h2f_dat),
        .h2fValid_out        (h2f_vld),
        .h2fReady_in         (h2f_rdy),
        .f2hData_in          (f2h_dat),
        .f2hValid_in         (f2h_vld),
        .f2hReady_out        (f2h_rdy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns channel index for a mapped address, -1 otherwise; st=1 for status channel.
    function automatic int decode(input logic [6:0] a, output bit st);
        int rel;
        rel = int'(a) - int'(BASE);
        st  = 1'b0;
        if (rel >= 0 && rel < 2 * NC) begin
            st = (rel % 2) == 1;
            return rel / 2;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic       e_room, e_gd, cd;
        logic [7:0] e_dout;
        bit         st;
        int         ch;
        e_room = 1'b1; e_gd = 1'b1; e_dout = 8'h00; cd = 1'b1;
        ch = decode(addr, st);
        if (ch >= 0 && !st) begin
            e_room = h2f_m[ch].size() < DEPTH;
            e_gd   = f2h_m[ch].size() != 0;
            if (f2h_m[ch].size() != 0) e_dout = f2h_m[ch][0];
            else                       cd = 1'b0;
        end else if (ch >= 0) begin
            e_dout = {h2f_m[ch].size() == DEPTH, h2f_m[ch].size() == 0,
                      f2h_m[ch].size() == DEPTH, f2h_m[ch].size() == 0,
                      ovf_m[ch], 3'b000};
        end
        chk("gotRoom", room, e_room);
        chk("gotData", gd, e_gd);
        if (cd) chk("dataToHost", dout, e_dout);
        for (int c = 0; c < NC; c++) begin
            chk("h2fValid", h2f_vld[c], h2f_m[c].size() != 0);
            if (h2f_m[c].size() != 0) chk("h2fData", h2f_dat[c*8 +: 8], h2f_m[c][0]);
            chk("f2hReady", f2h_rdy[c], f2h_m[c].size() < DEPTH);
        end
    endtask

    // Applies the behavioural rules for one clock edge using the inputs held across it.
    task automatic model_edge();
        bit st;
        int ch, hn, fn;
        bit dsel, ssel;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                h2f_m[c].delete();
                f2h_m[c].delete();
                ovf_m[c] = 1'b0;
            end
            return;
        end
        ch = decode(addr, st);
        for (int c = 0; c < NC; c++) begin
            dsel = (ch == c) && !st;
            ssel = (ch == c) && st;
            hn = h2f_m[c].size();
            fn = f2h_m[c].size();
            if (ssel && wr && din[2]) ovf_m[c] = 1'b0;
            if (dsel && wr && hn == DEPTH) ovf_m[c] = 1'b1;
            if (ssel && wr && din[0]) h2f_m[c].delete();
            else begin
                if (h2f_rdy[c] && hn > 0) void'(h2f_m[c].pop_front());
                if (dsel && wr && hn < DEPTH) h2f_m[c].push_back(din);
            end
            if (ssel && wr && din[1]) f2h_m[c].delete();
            else begin
                if (dsel && rd && fn > 0) void'(f2h_m[c].pop_front());
                if (f2h_vld[c] && fn < DEPTH) f2h_m[c].push_back(f2h_dat[c*8 +: 8]);
            end
        end
    endtask

    task automatic drive(input logic [6:0] a, input logic [7:0] d, input logic w, input logic r,
                         input logic [1:0] hr, input logic [1:0] fv, input logic [15:0] fd);
        addr = a; din = d; wr = w; rd = r; h2f_rdy = hr; f2h_vld = fv; f2h_dat = fd;
        #1;
        model_check();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; addr = 7'h00; din = 8'h00; wr = 1'b0; rd = 1'b0;
        h2f_rdy = 2'b00; f2h_vld = 2'b00; f2h_dat = 16'h0000;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        logic       w;
        logic       r;
        logic       room;
        logic       gd;
        logic [7:0] dout;
        logic       cd;
    } vec_t;

    vec_t vt [10];

    initial begin
        // Expectations for an empty bridge straight after reset.
        vt[0] = '{7'h10, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[1] = '{7'h11, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h50, 1'b1};
        vt[2] = '{7'h12, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[3] = '{7'h13, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h50, 1'b1};
        vt[4] = '{7'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
        vt[5] = '{7'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
        vt[6] = '{7'h14, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
        vt[7] = '{7'h7F, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
        vt[8] = '{7'h11, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h50, 1'b1};
        vt[9] = '{7'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};

        reset_dut();
        #1;
        chk("rst_h2fValid", h2f_vld, 2'b00);
        chk("rst_f2hReady", f2h_rdy, 2'b11);
        for (int k = 0; k < 10; k++) begin
            addr = vt[k].a; din = vt[k].d; wr = vt[k].w; rd = vt[k].r;
            #1;
            chk("vec_gotRoom", room, vt[k].room);
            chk("vec_gotData", gd, vt[k].gd);
            if (vt[k].cd) chk("vec_dataToHost", dout, vt[k].dout);
            step();
        end

        // Fill h2f[0] to full, overflow once; f2h[0] holds one byte so status is full+ovf only.
        reset_dut();
        drive(7'h00, 8'h00, 0, 0, 2'b00, 2'b01, 16'h005A); step();
        for (int k = 1; k <= 16; k++) begin
            drive(7'h10, 8'(k), 1, 0, 2'b00, 2'b00, 16'h0);
            step();
        end
        drive(7'h10, 8'h11, 1, 0, 2'b00, 2'b00, 16'h0);
        chk("full_gotRoom", room, 1'b0);
        step();
        drive(7'h11, 8'h00, 0, 1, 2'b00, 2'b00, 16'h0);
        chk("full_ovf_status", dout, 8'h88);
        step();
        for (int k = 1; k <= 16; k++) begin
            drive(7'h00, 8'h00, 0, 0, 2'b01, 2'b00, 16'h0);
            chk("drain_order", h2f_dat[7:0], 8'(k));
            step();
        end
        drive(7'h00, 8'h00, 0, 0, 2'b00, 2'b00, 16'h0);
        chk("drained_h2fValid", h2f_vld[0], 1'b0);
        step();

        // f2h[1] producer writes A0..A3, host reads them back on 0x12.
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            drive(7'h00, 8'h00, 0, 0, 2'b00, 2'b10, {8'(8'hA0 + k), 8'h00});
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(7'h12, 8'h00, 0, 1, 2'b00, 2'b00, 16'h0);
            chk("f2h_read", dout, 8'(8'hA0 + k));
            step();
        end
        drive(7'h12, 8'h00, 0, 0, 2'b00, 2'b00, 16'h0);
        chk("f2h_empty_gotData", gd, 1'b0);
        step();

        // Steady push+pop on h2f[0] at occupancy 8.
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            drive(7'h10, 8'(8'h20 + k), 1, 0, 2'b00, 2'b00, 16'h0);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            drive(7'h10, 8'(8'h28 + k), 1, 0, 2'b01, 2'b00, 16'h0);
            chk("steady_head", h2f_dat[7:0], 8'(8'h20 + k));
            step();
        end
        drive(7'h11, 8'h00, 0, 1, 2'b00, 2'b00, 16'h0);
        chk("steady_status", dout, 8'h10);
        step();
        for (int k = 0; k < 8; k++) begin
            drive(7'h00, 8'h00, 0, 0, 2'b01, 2'b00, 16'h0);
            chk("steady_tail", h2f_dat[7:0], 8'(8'h34 + k));
            step();
        end
        drive(7'h00, 8'h00, 0, 0, 2'b00, 2'b00, 16'h0);
        chk("steady_empty", h2f_vld[0], 1'b0);
        step();

        // Flush both FIFOs of pair 0 while the producer pushes on the same edge.
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            drive(7'h10, 8'(k), 1, 0, 2'b00, 2'b01, 16'(k));
            step();
        end
        drive(7'h11, 8'h03, 1, 0, 2'b00, 2'b01, 16'h0099);
        step();
        drive(7'h11, 8'h00, 0, 1, 2'b00, 2'b00, 16'h0);
        chk("flush_status", dout, 8'h50);
        chk("flush_h2fValid", h2f_vld[0], 1'b0);
        step();

        // Reset mid-burst with strobes active on the reset edge.
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            drive((k % 2 == 0) ? 7'h10 : 7'h12, 8'(k), 1, 0, 2'b00,
                  (k < 8) ? 2'b11 : 2'b00, 16'hC3C3);
            step();
        end
        rst = 1'b1;
        drive(7'h10, 8'hEE, 1, 0, 2'b00, 2'b11, 16'h7777);
        step();
        rst = 1'b0;
        drive(7'h11, 8'h00, 0, 1, 2'b00, 2'b00, 16'h0);
        chk("rst_mid_h2fValid", h2f_vld, 2'b00);
        chk("rst_mid_f2hReady", f2h_rdy, 2'b11);
        chk("rst_mid_status0", dout, 8'h50);
        step();
        drive(7'h13, 8'h00, 0, 1, 2'b00, 2'b00, 16'h0);
        chk("rst_mid_status1", dout, 8'h50);
        step();

        // Unmapped 0x7F with non-empty FIFOs: no side effects (model tracks occupancy).
        for (int k = 0; k < 2; k++) begin
            drive(7'h10, 8'(8'h40 + k), 1, 0, 2'b00, 2'b01, 16'h0061);
            step();
        end
        drive(7'h7F, 8'h00, 0, 1, 2'b00, 2'b00, 16'h0);
        chk("unmapped_data", dout, 8'h00);
        chk("unmapped_gotData", gd, 1'b1);
        chk("unmapped_gotRoom", room, 1'b1);
        step();
        drive(7'h7F, 8'h55, 1, 0, 2'b00, 2'b00, 16'h0);
        step();
        drive(7'h10, 8'h00, 0, 0, 2'b00, 2'b00, 16'h0);
        step();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] a;
            logic [7:0] d;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel < 6)       a = 7'(7'h0F + sel);
            else if (sel == 6) a = 7'h7F;
            else               a = 7'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 3) != 0) d[2:0] = 3'b000;
            rst = ($urandom_range(0, 299) == 0);
            drive(a, d, 1'($urandom), 1'($urandom),
                  {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
                  2'($urandom), 16'($urandom));
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
